// File: rtl/reset_seq_ctrl_pkg.sv
// Shared state encoding, default parameter values and sizing helper for the
// staged reset sequencer.
package reset_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD       = 2'd0,
        ST_REL_BUS    = 2'd1,
        ST_REL_PERIPH = 2'd2,
        ST_RUN        = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_FILTER_CYCLES  = 4;
    localparam int unsigned DEF_STRETCH_CYCLES = 16;
    localparam int unsigned DEF_STAGE_GAP      = 8;

    // Width able to hold max(a, b) - 1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for one asynchronous bit; a block reset
// preloads every stage with RST_VAL.
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] chain_q;

    // NOTE: sequential state uses non-blocking assignment so every stage samples the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= {DEPTH{RST_VAL}};
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staged reset sequencer: synchronise and filter reset sources, qualify against
// MMCM lock, stretch, then release interconnect, peripherals and core in order.
module reset_seq_ctrl
    import reset_seq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int unsigned STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP
) (
    input  logic clock,
    input  logic reset,
    input  logic ext_reset_in,
    input  logic aux_reset_in,
    input  logic mb_debug_sys_rst,
    input  logic dcm_locked,
    output logic bus_struct_reset,
    output logic interconnect_aresetn,
    output logic peripheral_reset,
    output logic peripheral_aresetn,
    output logic mb_reset,
    output logic seq_done
);

    localparam int unsigned CNT_W  = cnt_width(STRETCH_CYCLES, STAGE_GAP);
    localparam int unsigned FCNT_W = $clog2(FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0]  STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [FCNT_W-1:0] FILT_MAX     = FCNT_W'(FILTER_CYCLES);

    logic ext_s, aux_s, dbg_s, locked_s;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ext (
        .clk_i(clock), .rst_i(reset), .d_i(ext_reset_in), .q_o(ext_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_aux (
        .clk_i(clock), .rst_i(reset), .d_i(aux_reset_in), .q_o(aux_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dbg (
        .clk_i(clock), .rst_i(reset), .d_i(mb_debug_sys_rst), .q_o(dbg_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lock (
        .clk_i(clock), .rst_i(reset), .d_i(dcm_locked), .q_o(locked_s)
    );

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              req_c, qual_c, hold_c;
    logic              bus_rst_q, bus_rst_d;
    logic              periph_rst_q, periph_rst_d;
    logic              mb_rst_q, mb_rst_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_c  = ~ext_s | ~aux_s;
        fcnt_d = '0;
        if (req_c) begin
            fcnt_d = (fcnt_q == FILT_MAX) ? FILT_MAX : fcnt_q + FCNT_W'(1);
        end
        // Qualify on the run length including the current cycle.
        qual_c = (fcnt_d == FILT_MAX);
        hold_c = qual_c | dbg_s | ~locked_s;

        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == STRETCH_LAST) begin
                    state_d = ST_REL_BUS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL_BUS: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_REL_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL_PERIPH: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: ;
        endcase

        // A live request wins over any release decided above.
        if (hold_c) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end

        bus_rst_d    = (state_d == ST_HOLD);
        periph_rst_d = (state_d == ST_HOLD) || (state_d == ST_REL_BUS);
        mb_rst_d     = (state_d != ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            bus_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
            mb_rst_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            bus_rst_q    <= bus_rst_d;
            periph_rst_q <= periph_rst_d;
            mb_rst_q     <= mb_rst_d;
        end
    end

    assign bus_struct_reset     = bus_rst_q;
    assign interconnect_aresetn = ~bus_rst_q;
    assign peripheral_reset     = periph_rst_q;
    assign peripheral_aresetn   = ~periph_rst_q;
    assign mb_reset             = mb_rst_q;
    assign seq_done             = ~mb_rst_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: directed scenarios plus random reset
// bursts, checked every cycle against a run-length reference model.
module tb_reset_seq_ctrl;
    import reset_seq_ctrl_pkg::*;

    localparam int SYNC    = DEF_SYNC_STAGES;
    localparam int FILT    = DEF_FILTER_CYCLES;
    localparam int STRETCH = DEF_STRETCH_CYCLES;
    localparam int GAP     = DEF_STAGE_GAP;

    logic clock = 1'b0;
    logic reset, ext_reset_in, aux_reset_in, mb_debug_sys_rst, dcm_locked;
    logic bus_struct_reset, interconnect_aresetn, peripheral_reset;
    logic peripheral_aresetn, mb_reset, seq_done;

    reset_seq_ctrl #(
        .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT),
        .STRETCH_CYCLES(STRETCH), .STAGE_GAP(GAP)
    ) dut (
        .clock(clock), .reset(reset),
        .ext_reset_in(ext_reset_in), .aux_reset_in(aux_reset_in),
        .mb_debug_sys_rst(mb_debug_sys_rst), .dcm_locked(dcm_locked),
        .bus_struct_reset(bus_struct_reset), .interconnect_aresetn(interconnect_aresetn),
        .peripheral_reset(peripheral_reset), .peripheral_aresetn(peripheral_aresetn),
        .mb_reset(mb_reset), .seq_done(seq_done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t  exp_q[$];
    string phase = "init";

    // Reference model: each synchronised input is the value seen SYNC edges
    // earlier; release depends only on how many clean cycles have elapsed.
    bit ext_dq[$], aux_dq[$], dbg_dq[$], lock_dq[$];
    int req_run = 0;
    int clean   = 0;
    bit valid   = 0;

    task automatic model_edge();
        bit   req, hold;
        bit   b, p, m;
        exp_t e;
        if (reset) begin
            ext_dq = {}; aux_dq = {}; dbg_dq = {}; lock_dq = {};
            for (int i = 0; i < SYNC; i++) begin
                ext_dq.push_back(1'b0);
                aux_dq.push_back(1'b0);
                dbg_dq.push_back(1'b1);
                lock_dq.push_back(1'b0);
            end
            req_run = 0;
            clean   = 0;
            valid   = 1;
        end else if (valid) begin
            req     = !ext_dq[0] || !aux_dq[0];
            req_run = req ? req_run + 1 : 0;
            hold    = (req_run >= FILT) || dbg_dq[0] || !lock_dq[0];
            if (req_run > FILT) req_run = FILT;
            clean = hold ? 0 : clean + 1;
            if (clean > STRETCH + 2 * GAP) clean = STRETCH + 2 * GAP;
            void'(ext_dq.pop_front());  ext_dq.push_back(ext_reset_in);
            void'(aux_dq.pop_front());  aux_dq.push_back(aux_reset_in);
            void'(dbg_dq.pop_front());  dbg_dq.push_back(mb_debug_sys_rst);
            void'(lock_dq.pop_front()); lock_dq.push_back(dcm_locked);
        end
        if (valid) begin
            b = (clean < STRETCH);
            p = (clean < STRETCH + GAP);
            m = (clean < STRETCH + 2 * GAP);
            e.v   = {b, ~b, p, ~p, m, ~m};
            e.tag = phase;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        reset            = 1'b0;
        ext_reset_in     = 1'b1;
        aux_reset_in     = 1'b1;
        mb_debug_sys_rst = 1'b0;
        dcm_locked       = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a full output vector.
    exp_t mon_item;
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_item = exp_q.pop_front();
            check({"outputs_", mon_item.tag},
                  {26'd0, bus_struct_reset, interconnect_aresetn, peripheral_reset,
                   peripheral_aresetn, mb_reset, seq_done},
                  {26'd0, mon_item.v});
        end
    end

    int bus_at, per_at, core_at;

    initial begin
        idle_inputs();
        reset = 1'b1;
        phase = "reset";
        repeat (3) step();

        // Power-up: count edges after the last reset edge until each release.
        reset  = 1'b0;
        phase  = "powerup";
        bus_at = 0; per_at = 0; core_at = 0;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (bus_at == 0 && bus_struct_reset == 1'b0) bus_at = i;
            if (per_at == 0 && peripheral_reset == 1'b0) per_at = i;
            if (core_at == 0 && mb_reset == 1'b0) core_at = i;
        end
        check("bus_release_edge", bus_at, SYNC + STRETCH);
        check("periph_release_edge", per_at, SYNC + STRETCH + GAP);
        check("core_release_edge", core_at, SYNC + STRETCH + 2 * GAP);

        phase = "glitch_short";
        ext_reset_in = 1'b0;
        repeat (FILT - 1) step();
        ext_reset_in = 1'b1;
        repeat (20) step();

        phase = "glitch_qual";
        ext_reset_in = 1'b0;
        repeat (FILT) step();
        ext_reset_in = 1'b1;
        repeat (45) step();

        phase = "debug_pulse";
        mb_debug_sys_rst = 1'b1;
        step();
        mb_debug_sys_rst = 1'b0;
        repeat (45) step();

        phase = "lock_loss_periph";
        dcm_locked = 1'b0;
        step();
        dcm_locked = 1'b1;
        repeat (30) step();
        dcm_locked = 1'b0;
        step();
        dcm_locked = 1'b1;
        repeat (45) step();

        // Lock falls so that it reaches the synchroniser output on the stretch terminal cycle.
        phase = "simultaneous";
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (STRETCH - 1) step();
        dcm_locked = 1'b0;
        repeat (2) step();
        dcm_locked = 1'b1;
        repeat (45) step();

        phase = "reset_in_run";
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (45) step();

        phase = "random";
        for (int burst = 0; burst < 25; burst++) begin
            int kind, len, quiet;
            kind  = $urandom_range(0, 4);
            len   = $urandom_range(1, 6);
            quiet = $urandom_range(0, 45);
            case (kind)
                0: ext_reset_in     = 1'b0;
                1: aux_reset_in     = 1'b0;
                2: mb_debug_sys_rst = 1'b1;
                3: dcm_locked       = 1'b0;
                default: reset      = 1'b1;
            endcase
            repeat (len) step();
            idle_inputs();
            repeat (quiet) step();
        end

        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
